// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and
// the quotient returned on a divide by zero.
package div_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StIter = S_ITER,
    StFix  = S_FIX
  } div_state_e;

  // Sliced to WIDTH by the user, so WIDTH must not exceed 128.
  localparam logic [127:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   p,
  input  logic             a_msb,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   p_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {p, a_msb};
  assign diff    = shifted - {2'b00, b};

  always_comb begin
    q_bit  = ~diff[WIDTH+1];
    p_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (signed/unsigned) with start/done handshake.
// Operates on magnitudes and applies the result signs in a final fix-up cycle.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             dvd_neg, dsr_neg;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH:0]   step_p;
  logic             step_q;

  // Negating min_neg wraps to itself, which is exactly its unsigned magnitude.
  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dsr_neg = is_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dsr_mag = dsr_neg ? -divisor : divisor;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .p      (p_q),
    .a_msb  (a_q[WIDTH-1]),
    .b      (b_q),
    .p_next (step_p),
    .q_bit  (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    a_d     = a_q;
    b_d     = b_q;
    orig_d  = orig_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = dvd_mag;
          b_d     = dsr_mag;
          orig_d  = dividend;
          q_neg_d = dvd_neg ^ dsr_neg;
          r_neg_d = dvd_neg;
          zero_d  = (divisor == '0);
          p_d     = '0;
          cnt_d   = '0;
          state_d = StIter;
        end
      end
      StIter: begin
        // The dividend register doubles as the quotient shift register.
        p_d   = step_p;
        a_d   = {a_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (zero_q) begin
          quot_d = DIV0_QUOT[WIDTH-1:0];
          rem_d  = orig_q;
          dz_d   = 1'b1;
        end else begin
          quot_d = q_neg_q ? -a_q : a_q;
          rem_d  = r_neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
          dz_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt_q   <= '0;
      p_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      orig_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      a_q     <= a_d;
      b_q     <= b_d;
      orig_q  <= orig_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32): directed vectors, an
// arithmetic reference model and a per-cycle scoreboard of busy/done/results.
module tb_seq_divider;

  localparam int unsigned W = 32;
  localparam int LAT = 33;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           acc;
    int           dcyc;
  } exp_t;

  exp_t expq[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, with the zero-divisor rule on top.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    longint sa, sb, sq, sr;
    if (b == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else if (!s) begin
      q  = a / b;
      r  = a % b;
      dz = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[W-1:0];
      r  = sr[W-1:0];
      dz = 1'b0;
    end
  endfunction

  // Must be called at a negedge; returns the accept cycle.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output int c0);
    exp_t e;
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    @(posedge clock);
    #1;
    model(a, b, s, e.q, e.r, e.dz);
    e.acc  = cyc;
    e.dcyc = cyc + LAT;
    expq.push_back(e);
    c0 = cyc;
    @(negedge clock);
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = ~s;
  endtask

  // Returns at the negedge of the done cycle (or after the budget runs out).
  task automatic wait_done(input int c0, output int lat);
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) begin
        lat = cyc - c0;
        break;
      end
      @(negedge clock);
    end
    check("latency", lat, LAT);
  endtask

  // Scoreboard: busy every cycle, results and timing on each done pulse.
  always @(negedge clock) begin
    logic busy_exp;
    if (!clear) begin
      busy_exp = (expq.size() > 0) && (cyc >= expq[0].acc) && (cyc < expq[0].dcyc);
      check("busy", {31'b0, busy}, {31'b0, busy_exp});
      if (done === 1'b1) begin
        if (expq.size() == 0) begin
          check("unexpected_done", {31'b0, done}, 0);
        end else begin
          check("done_cycle", cyc, expq[0].dcyc);
          check("quotient", quotient, expq[0].q);
          check("remainder", remainder, expq[0].r);
          check("div_by_zero", {31'b0, div_by_zero}, {31'b0, expq[0].dz});
          void'(expq.pop_front());
        end
      end else if (expq.size() > 0 && cyc >= expq[0].dcyc) begin
        check("missing_done", {31'b0, done}, 1);
        void'(expq.pop_front());
      end
    end
  end

  vec_t vecs[13];

  initial begin
    int c0, lat;
    logic [W-1:0] mq, mr;
    logic mdz;

    vecs = '{
      '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0},
      '{32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0},
      '{32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,   32'd2,          1'b0},
      '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   1'b0},
      '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0},
      '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0},
      '{32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          1'b0},
      '{32'd1234,       32'd0,          1'b0, 32'hFFFFFFFF,   32'd1234,       1'b1},
      '{32'd1234,       32'd0,          1'b1, 32'hFFFFFFFF,   32'd1234,       1'b1},
      '{32'd7,          32'd3,          1'b0, 32'd2,          32'd1,          1'b0},
      '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0,          1'b0},
      '{32'hFFFFFFFF,   32'd2,          1'b0, 32'h7FFFFFFF,   32'd1,          1'b0},
      '{32'h80000000,   32'd3,          1'b1, 32'hD5555556,   32'hFFFFFFFE,   1'b0}
    };

    clear     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dz", {31'b0, div_by_zero}, 0);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    // Directed table: pin the model, then the DUT, against hand-computed values.
    foreach (vecs[i]) begin
      model(vecs[i].a, vecs[i].b, vecs[i].s, mq, mr, mdz);
      check($sformatf("model_q[%0d]", i), mq, vecs[i].q);
      check($sformatf("model_r[%0d]", i), mr, vecs[i].r);
      issue(vecs[i].a, vecs[i].b, vecs[i].s, c0);
      wait_done(c0, lat);
      check($sformatf("vec_q[%0d]", i), quotient, vecs[i].q);
      check($sformatf("vec_r[%0d]", i), remainder, vecs[i].r);
      check($sformatf("vec_dz[%0d]", i), {31'b0, div_by_zero}, {31'b0, vecs[i].dz});
      @(negedge clock);
    end

    // A start while busy must be ignored.
    issue(32'd1000, 32'd10, 1'b0, c0);
    repeat (5) @(negedge clock);
    start    = 1'b1;
    dividend = 32'd7;
    divisor  = 32'd2;
    @(negedge clock);
    start = 1'b0;
    wait_done(c0, lat);
    check("busy_start_q", quotient, 32'd100);
    check("busy_start_r", remainder, 32'd0);

    // Back-to-back: start asserted in the done cycle.
    @(negedge clock);
    issue(32'd50, 32'd6, 1'b0, c0);
    wait_done(c0, lat);
    check("b2b_first_q", quotient, 32'd8);
    issue(32'd77, 32'd5, 1'b0, c0);
    wait_done(c0, lat);
    check("b2b_second_q", quotient, 32'd15);
    check("b2b_second_r", remainder, 32'd2);

    // Asynchronous clear mid-operation.
    @(negedge clock);
    issue(32'd12345678, 32'd9, 1'b0, c0);
    repeat (9) @(posedge clock);
    #2;
    clear = 1'b1;
    expq.delete();
    #1;
    check("clr_busy", {31'b0, busy}, 0);
    check("clr_done", {31'b0, done}, 0);
    check("clr_quotient", quotient, 0);
    check("clr_remainder", remainder, 0);
    check("clr_dz", {31'b0, div_by_zero}, 0);
    @(negedge clock);
    #1;
    clear = 1'b0;
    repeat (40) @(negedge clock);

    issue(32'd10, 32'd3, 1'b0, c0);
    wait_done(c0, lat);
    check("post_clr_q", quotient, 32'd3);
    check("post_clr_r", remainder, 32'd1);
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multi-cycle restoring divider for the datapath DIV instruction.
- Computes quotient (LO) and remainder (HI) in signed or unsigned mode.
- Uses one subtract/restore step per clock under a start/done handshake.
- Sits beside the ALU; the control unit stalls on busy and latches HI/LO on done.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clock  input  1  rising-edge clock
clear  input  1  asynchronous active-high reset
start  input  1  request; sampled only when busy=0
is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start
dividend  input  WIDTH  numerator A; sampled with start
divisor  input  WIDTH  denominator B; sampled with start
busy  output  1  high from the cycle after accept until done is asserted
done  output  1  one-cycle pulse; quotient/remainder valid from this cycle
quotient  output  WIDTH  LO result, held until next done
remainder  output  WIDTH  HI result, held until next done
div_by_zero  output  1  set with done when divisor==0, held until next done

Behaviour:
- Reset (clear=1, async): state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; counter = 0.
- States: IDLE -> ITER -> FIX -> IDLE.
- IDLE:
  - start=1 at edge E0 -> capture the operands, the sign mode and the sign flags.
  - In signed mode, load |dividend| and |divisor|; magnitude is WIDTH bits unsigned, so |min_neg| = 2^(WIDTH-1) is representable.
  - Clear the WIDTH+1 bit partial remainder; counter=0; go to ITER.
- ITER, one step per edge E1..E_WIDTH:
  - Shift {P,A} left by one.
  - Compute P-B at WIDTH+1 bits.
  - If the result is negative: restore P and shift in q=0; else keep the result and shift in q=1.
  - counter++; leave ITER after WIDTH steps.
- FIX, edge E_{WIDTH+1}:
  - Apply signs: quotient negated iff signs differ; remainder takes the sign of the dividend.
  - Register the outputs, pulse done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: done is high WIDTH+1 cycles after the accept edge (33 for WIDTH=32).
- Back-to-back operation: a new start is accepted in the done cycle.
- busy=1 during ITER and FIX only.
- start while busy: ignored; the operation in flight is unaffected.
- Divide by zero:
  - Same latency, no early exit.
  - quotient = all ones; remainder = original dividend; div_by_zero=1.
  - Rule applies in both modes.
- Signed overflow (min_neg / -1): quotient = min_neg, remainder = 0, div_by_zero=0.
- Zero dividend: quotient=0, remainder=0.
- Operand input changes after accept have no effect.
- clear mid-operation: abort immediately to reset values; no done pulse.
- All arithmetic is internally WIDTH+1 bits; no output truncation beyond WIDTH.

Decomposition:
- Shared package div_pkg:
  - state encoding localparams: S_IDLE=2'd0, S_ITER=2'd1, S_FIX=2'd2
  - DIV0_QUOT constant (all ones)
- Natural sub-module div_step: combinational single restoring step.
  - Inputs: P (WIDTH+1), A msb, B.
  - Outputs: next P, quotient bit.
  - Keeps the sequential wrapper to the FSM, counter and sign handling.

Test Plan:
- Unsigned, WIDTH=32: dividend=100, divisor=7, is_signed=0 -> done at exactly 33 cycles after accept; quotient=14, remainder=2, div_by_zero=0; busy high for 33 cycles.
- Signed sign combinations:
  - -100 / 7 -> q=-14 (0xFFFFFFF2), r=-2 (0xFFFFFFFE)
  - 100 / -7 -> q=-14, r=2
  - -100 / -7 -> q=14, r=-2
- Boundaries:
  - 0xFFFFFFFF / 1 unsigned -> q=0xFFFFFFFF, r=0.
  - 0x80000000 / 0xFFFFFFFF signed -> q=0x80000000, r=0.
  - 5 / 9 -> q=0, r=5.
- Divide by zero: 1234 / 0 (both modes) -> q=0xFFFFFFFF, r=1234, div_by_zero=1, same 33-cycle latency; next valid divide clears div_by_zero.
- Handshake:
  - start pulsed mid-operation with different operands -> ignored, first result unchanged.
  - start held in the done cycle -> second op accepted and completes 33 cycles later.
- Reset: assert clear asynchronously (between edges) at cycle 10 of an operation -> busy/done/outputs go to 0 immediately, no done pulse; a fresh 10/3 afterwards yields q=3, r=1.
